// File: rtl/joy_serial_reader.sv
`default_nettype none
// ============================================================================
// joy_serial_reader : load/shift driver for a 74HC165-style joystick chain
//                     with per-bit multi-frame debounce
// Revision 1.0
// ============================================================================
module joy_serial_reader #(
  parameter int NUM_JOYS        = 2,
  parameter int BITS_PER_JOY    = 8,
  parameter int CLKDIV_LOG2     = 7,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter bit OUT_ACTIVE_LOW  = 1'b0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             joy_data,
  output logic                             joy_clk,
  output logic                             joy_load_n,
  output logic [NUM_JOYS*BITS_PER_JOY-1:0] joy_out,
  output logic                             frame_strobe
);

  localparam int TOTAL = NUM_JOYS * BITS_PER_JOY;
  localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(TOTAL - 1);
  localparam logic [TOTAL-1:0] OUT_RESET = {TOTAL{OUT_ACTIVE_LOW}};

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    SHIFT_LOW  = 3'd2,
    SHIFT_HIGH = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic [CLKDIV_LOG2-1:0] div;
  logic                   tick;
  logic                   load_half, load_half_nxt;
  logic [CNT_W-1:0]       bitcnt, bitcnt_nxt;
  logic [TOTAL-1:0]       raw, raw_nxt;
  logic [TOTAL-1:0]       hist     [DEBOUNCE_FRAMES];
  logic [TOTAL-1:0]       hist_nxt [DEBOUNCE_FRAMES];
  logic [TOTAL-1:0]       all_high, all_low, out_nxt;
  logic                   joy_clk_nxt, joy_load_n_nxt, strobe_nxt;

  assign tick = &div;

  always_ff @(posedge clk) begin
    if (reset) begin
      div          <= '0;
      state        <= IDLE;
      load_half    <= 1'b0;
      bitcnt       <= '0;
      raw          <= '1;
      joy_clk      <= 1'b0;
      joy_load_n   <= 1'b1;
      frame_strobe <= 1'b0;
      joy_out      <= OUT_RESET;
      for (int i = 0; i < DEBOUNCE_FRAMES; i++) hist[i] <= '1;
    end else begin
      div          <= div + CLKDIV_LOG2'(1);
      state        <= state_nxt;
      load_half    <= load_half_nxt;
      bitcnt       <= bitcnt_nxt;
      raw          <= raw_nxt;
      joy_clk      <= joy_clk_nxt;
      joy_load_n   <= joy_load_n_nxt;
      frame_strobe <= strobe_nxt;
      joy_out      <= out_nxt;
      hist         <= hist_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_half_nxt  = load_half;
    bitcnt_nxt     = bitcnt;
    raw_nxt        = raw;
    joy_clk_nxt    = joy_clk;
    joy_load_n_nxt = joy_load_n;
    strobe_nxt     = 1'b0;
    out_nxt        = joy_out;
    hist_nxt       = hist;

    // Agreement across the history as it will be once this frame is pushed in
    all_high = raw;
    all_low  = ~raw;
    for (int i = 0; i < DEBOUNCE_FRAMES - 1; i++) begin
      all_high &= hist[i];
      all_low  &= ~hist[i];
    end

    case (state)
      IDLE: begin
        if (tick && enable) begin
          state_nxt      = LOAD;
          joy_load_n_nxt = 1'b0;
          load_half_nxt  = 1'b0;
        end
      end
      LOAD: begin
        if (tick) begin
          if (load_half) begin
            state_nxt      = SHIFT_LOW;
            joy_load_n_nxt = 1'b1;
            bitcnt_nxt     = '0;
          end else begin
            load_half_nxt = 1'b1;
          end
        end
      end
      SHIFT_LOW: begin
        if (tick) begin
          raw_nxt[bitcnt] = joy_data;
          joy_clk_nxt     = 1'b1;
          state_nxt       = SHIFT_HIGH;
        end
      end
      SHIFT_HIGH: begin
        if (tick) begin
          joy_clk_nxt = 1'b0;
          if (bitcnt == LAST_BIT) begin
            state_nxt = DONE;
          end else begin
            bitcnt_nxt = bitcnt + CNT_W'(1);
            state_nxt  = SHIFT_LOW;
          end
        end
      end
      DONE: begin
        hist_nxt[0] = raw;
        for (int i = 1; i < DEBOUNCE_FRAMES; i++) hist_nxt[i] = hist[i-1];
        out_nxt    = (joy_out & ~(all_high | all_low)) |
                     (OUT_ACTIVE_LOW ? all_high : all_low);
        strobe_nxt = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire
